sd_blk_addr_seq: RTL

- Upstream controller for the loadable 32-bit block-address counter in the SD-SPI test system.
- Drives the counter's clear/write/up/data inputs and reads back its q value.
- Issues one block request per address to the SD-SPI transfer engine, from base_addr through base_addr+num_blocks-1.
- Reports completion or error to the test sequencer.

---
 rtl/sd_seq_pkg.sv | 24 ++
 rtl/sd_seq_watchdog.sv | 38 +++
 rtl/sd_blk_addr_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sd_seq_pkg.sv
// Shared definitions for the SD-SPI block-address sequencer: state codes,
// address width and the default watchdog limit.
package sd_seq_pkg;

  localparam int ADDR_W             = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_REQ  = 3'd2;
  localparam logic [2:0] ST_NEXT = 3'd3;
  localparam logic [2:0] ST_CLR  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_REQ  = ST_REQ,
    S_NEXT = ST_NEXT,
    S_CLR  = ST_CLR,
    S_DONE = ST_DONE
  } seq_state_t;

endpackage

// File: rtl/sd_seq_watchdog.sv
// Request watchdog: counts enabled cycles since the last kick and flags the
// cycle on which the count reaches TIMEOUT_CYCLES.
module sd_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic kick,
  output logic expired
);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (kick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of earlier waiting cycles, so the limit is hit
  // on the TIMEOUT_CYCLES-th consecutive waiting cycle.
  assign expired = en && !kick && (count_q == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sd_blk_addr_seq.sv
// Block-address sequencer: loads the external address counter, issues one block
// request per address and reports done/error. Watchdog enabled by SEQ_TIMEOUT_EN.
module sd_blk_addr_seq
  import sd_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_W           = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_blocks,
  input  logic [ADDR_W-1:0] cnt_q,
  output logic              cnt_cl,
  output logic              cnt_w,
  output logic              cnt_up,
  output logic [ADDR_W-1:0] cnt_d,
  output logic              blk_req,
  output logic [ADDR_W-1:0] blk_addr,
  input  logic              blk_ack,
  output logic              busy,
  output logic              done,
  output logic              error
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0] load_val_q, load_val_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              error_q, error_d;
  logic              wd_expired;

`ifdef SEQ_TIMEOUT_EN
  sd_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == S_REQ),
    .kick   (blk_ack || (state_q != S_REQ)),
    .expired(wd_expired)
  );
`else
  logic [TO_W-1:0] unused_timeout;
  assign unused_timeout = TO_W'(TIMEOUT_CYCLES);
  assign wd_expired     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    load_val_d  = load_val_q;
    addr_d      = addr_q;
    error_d     = error_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          error_d = 1'b0;
          if (num_blocks != '0) begin
            remaining_d = num_blocks;
            load_val_d  = base_addr;
            state_d     = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        // Mirror the address the counter will present so blk_addr stays registered.
        addr_d  = load_val_q;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (blk_ack) begin
          if (remaining_q == ADDR_W'(1)) begin
            state_d = S_DONE;
          end else if (cnt_q == '1) begin
            error_d = 1'b1;
            state_d = S_CLR;
          end else begin
            remaining_d = remaining_q - ADDR_W'(1);
            state_d     = S_NEXT;
          end
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = S_CLR;
        end
      end
      S_NEXT: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_REQ;
      end
      S_CLR:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An abort cancels quietly: no error, but the counter is still cleared.
    if (abort && (state_q != S_IDLE) && (state_q != S_CLR)) begin
      state_d     = S_CLR;
      error_d     = error_q;
      remaining_d = remaining_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      load_val_q  <= '0;
      addr_q      <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      load_val_q  <= load_val_d;
      addr_q      <= addr_d;
      error_q     <= error_d;
    end
  end

  assign cnt_w    = (state_q == S_LOAD);
  assign cnt_up   = (state_q == S_NEXT);
  assign cnt_cl   = (state_q == S_CLR);
  assign blk_req  = (state_q == S_REQ);
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q == S_LOAD) || (state_q == S_REQ) ||
                    (state_q == S_NEXT) || (state_q == S_CLR);
  assign cnt_d    = load_val_q;
  assign blk_addr = addr_q;
  assign error    = error_q;

endmodule
